wave_ctrl: RTL and testbench
============================

Name: wave_ctrl

Overview:
Configuration controller and sequencer for the four-channel wave datapath.
- Accepts host register writes into per-channel shadow registers.
- Commits them atomically on a sample-frame boundary, so all fields of a channel change in the same cycle.
- Drives the 64-bit amps/offsets/phasewords buses and the per-channel clock-enable strobes (clks) consumed by the four-channel generator block.

Parameters:
DIV_W, 16, width of per-channel clock-divider count
RAMP_STEP, 16'd64, amplitude step per frame_tick (used only with optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (reset==0 resets on rising clk)
wr_valid  in  1  host write request
wr_ready  out  1  controller can accept write
wr_addr  in  5  [4:3] channel, [2:0] field; 5'h1F = commit register
wr_data  in  16  write data
frame_tick  in  1  one-cycle sample-frame boundary strobe
amps  out  64  signed amplitudes, ch3 in [63:48] … ch0 in [15:0]
offsets  out  64  phase offsets, same packing
phasewords  out  64  phase increments, same packing
clks  out  4  per-channel one-cycle clock-enable strobes
busy  out  1  commit pending or in progress

Behaviour:
- Field map: 0 amp, 1 offset, 2 phaseword, 3 divisor, 4 run bit (wr_data[0]); fields 5–7 ignored (write accepted, no effect).
- Handshake: transfer when wr_valid && wr_ready. Shadow register updates on the same edge. wr_ready is combinational on state.
- Commit: write to 5'h1F with wr_data[3:0] = channel mask.
  - Mask 0: accepted, no state change, no busy.
  - Nonzero mask: latched; FSM enters WAIT.
- FSM states: IDLE → WAIT (nonzero commit accepted) → APPLY (frame_tick seen in WAIT) → IDLE.
  - WAIT ignores a frame_tick that arrives in the same cycle as the commit write; the next tick is used.
  - APPLY lasts 1 cycle: active registers ← shadow for masked channels; divider counters of masked channels reset to 0.
  - wr_ready = 1 only in IDLE. busy = 1 in WAIT and APPLY.
- Outputs are registered. New values are visible the cycle after APPLY, i.e. 2 cycles after the frame_tick edge.
- Dividers: per channel, when run = 1:
  - counter increments each cycle.
  - At counter == divisor: clks[i] pulses 1 cycle and counter returns to 0.
  - Divisor 0 → clks[i] high every cycle.
  - run = 0 → counter held at 0, clks[i] = 0.
- Shadow writes never affect outputs before APPLY. A shadow rewrite before commit: last value wins.
- Arithmetic: no arithmetic on datapath fields except the optional ramp. Fields pass through unchanged.
- Reset (any state, including WAIT):
  - all shadow and active registers 0; counters 0; mask 0.
  - amps/offsets/phasewords/clks = 0, busy = 0, FSM IDLE.
  - wr_ready = 0 during reset, 1 the first cycle after.

Optional Feature:
Macro WAVE_CTRL_AMP_RAMP_EN.
- Defined: APPLY commits all fields except amplitude. For each masked channel, the active amp moves toward its shadow target by RAMP_STEP on each frame_tick:
  - signed compare;
  - clamp to target when |diff| ≤ RAMP_STEP;
  - no overshoot, no wrap.
- busy stays 1 until every ramp reaches its target. wr_ready stays 0 until then.
- Undefined: amplitude jumps at APPLY with the other fields.

Decomposition:
- Package wave_ctrl_pkg holds:
  - field-code constants (FLD_AMP … FLD_RUN), COMMIT_ADDR = 5'h1F, NUM_CH = 4;
  - FSM state enum (IDLE, WAIT, APPLY);
  - per-channel config struct {amp, offset, phaseword, divisor, run}.
- One sub-module: wave_ctrl_div, the per-channel clock-enable divider (run, divisor, clear → strobe), instantiated 4 times.

Test Plan:
- Reset, then write ch0 amp = 16'h1234, commit mask 4'h1, pulse frame_tick → amps[15:0] = 16'h1234 two cycles after the tick edge; other channels stay 0; busy high from commit until APPLY.
- ch2 divisor = 3, run = 1, commit mask 4'h4 → clks[2] pulses every 4th cycle; clks[0,1,3] stay 0.
- Commit pending (no tick yet), host asserts wr_valid → wr_ready = 0; write is held by host and accepted the cycle after APPLY.
- Commit write and frame_tick in the same cycle → no apply; the next frame_tick applies.
- reset asserted in WAIT → all outputs 0, busy 0; a later frame_tick changes nothing.
- With WAVE_CTRL_AMP_RAMP_EN: ch1 amp 0 → 16'sd200, RAMP_STEP = 64 → amps[31:16] = 64, 128, 192, 200 on successive ticks; busy drops after 200.

Source files
------------

// File: rtl/wave_ctrl_pkg.sv
// Shared definitions for the wave_ctrl configuration controller: field codes,
// the commit address, the sequencer state encoding, the per-channel config
// record and the amplitude ramp helper.
package wave_ctrl_pkg;

  localparam int NUM_CH = 4;

  localparam logic [2:0] FLD_AMP    = 3'd0;
  localparam logic [2:0] FLD_OFFSET = 3'd1;
  localparam logic [2:0] FLD_PHASE  = 3'd2;
  localparam logic [2:0] FLD_DIV    = 3'd3;
  localparam logic [2:0] FLD_RUN    = 3'd4;

  localparam logic [4:0] COMMIT_ADDR = 5'h1F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    APPLY = 2'd2
  } state_t;

  // One channel's worth of configuration, held both as shadow and active copy.
  typedef struct packed {
    logic [15:0] amp;
    logic [15:0] offset;
    logic [15:0] phaseword;
    logic [15:0] divisor;
    logic        run;
  } ch_cfg_t;

  // Move a signed amplitude one step toward its target. The difference is
  // formed one bit wider so the compare never wraps, and the result lands
  // exactly on the target once it is within one step.
  function automatic logic [15:0] ramp_toward(input logic [15:0] cur,
                                              input logic [15:0] tgt,
                                              input logic [15:0] step);
    logic signed [16:0] diff;
    logic signed [16:0] lim;
    diff = $signed({tgt[15], tgt}) - $signed({cur[15], cur});
    lim  = $signed({1'b0, step});
    if (diff > lim)       return cur + step;
    else if (diff < -lim) return cur - step;
    else                  return tgt;
  endfunction

endpackage

// File: rtl/wave_ctrl_if.sv
// Host register-write bus of wave_ctrl: valid/ready handshake with a 5-bit
// address ([4:3] channel, [2:0] field, 5'h1F = commit) and 16-bit data.
interface wave_ctrl_if;
  logic        valid;
  logic        ready;
  logic [4:0]  addr;
  logic [15:0] data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/wave_ctrl_div.sv
// Per-channel clock-enable divider. While run is high the counter walks
// 0..divisor and the strobe pulses for one cycle each time it hits divisor
// (divisor 0 gives a strobe every cycle). clear restarts the count at 0.
module wave_ctrl_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [DIV_W-1:0] divisor,
  input  logic             clear,
  output logic             strobe
);

  logic [DIV_W-1:0] cnt_q;
  logic             hit;

  assign hit = (cnt_q == divisor);

  // Count and register the strobe; stopped or cleared channels sit at 0.
  // NOTE: state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset || clear || !run) begin
      cnt_q  <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= hit;
      cnt_q  <= hit ? '0 : cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/wave_ctrl.sv
// wave_ctrl: configuration controller and sequencer for the four-channel wave
// datapath. Host writes land in shadow registers; a commit names a channel
// mask, and on the next frame_tick the masked channels' active registers are
// loaded from shadow in a single cycle, restarting their clock dividers.
// Optional build macro WAVE_CTRL_AMP_RAMP_EN: amplitude is not loaded at
// commit but ramps toward the shadow value by RAMP_STEP per frame_tick.
module wave_ctrl
  import wave_ctrl_pkg::*;
#(
  parameter int          DIV_W     = 16,
  parameter logic [15:0] RAMP_STEP = 16'd64
) (
  input  logic         clk,
  input  logic         reset,
  wave_ctrl_if.slave   wr,
  input  logic         frame_tick,
  output logic [63:0]  amps,
  output logic [63:0]  offsets,
  output logic [63:0]  phasewords,
  output logic [3:0]   clks,
  output logic         busy
);

  state_t            state_q, state_d;
  ch_cfg_t           shadow_q [NUM_CH];
  ch_cfg_t           active_q [NUM_CH];
  logic [NUM_CH-1:0] mask_q;

  logic              wr_ready;
  logic              wr_fire;
  logic              is_commit;
  logic              commit_fire;
  logic              apply;
  logic              ramp_busy;
  logic [1:0]        wr_ch;
  logic [2:0]        wr_fld;

  assign wr_ch       = wr.addr[4:3];
  assign wr_fld      = wr.addr[2:0];
  assign is_commit   = (wr.addr == COMMIT_ADDR);
  assign wr_ready    = reset && (state_q == IDLE) && !ramp_busy;
  assign wr.ready    = wr_ready;
  assign wr_fire     = wr.valid && wr_ready;
  assign commit_fire = wr_fire && is_commit && (wr.data[3:0] != 4'h0);

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and status: a commit in IDLE arms WAIT, so a frame_tick in
  // that same cycle is not yet looked at; the following tick moves to APPLY.
  // NOTE: every output of this block gets a default first so no latch forms.
  always_comb begin
    state_d = state_q;
    apply   = 1'b0;
    busy    = ramp_busy;
    unique case (state_q)
      IDLE: begin
        if (commit_fire) state_d = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (frame_tick) state_d = APPLY;
      end
      APPLY: begin
        busy    = 1'b1;
        apply   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef WAVE_CTRL_AMP_RAMP_EN
  logic [15:0]       amp_step [NUM_CH];
  logic [NUM_CH-1:0] ramp_q;

  // Candidate next amplitude of each channel, one step toward its target.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      amp_step[i] = ramp_toward(active_q[i].amp, shadow_q[i].amp, RAMP_STEP);
    end
  end

  // Ramp-in-progress flags: armed at APPLY, dropped once the target is hit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ramp_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (apply && mask_q[i])
          ramp_q[i] <= (amp_step[i] != shadow_q[i].amp);
        else if (frame_tick && ramp_q[i])
          ramp_q[i] <= (amp_step[i] != shadow_q[i].amp);
      end
    end
  end

  assign ramp_busy = |ramp_q;
`else
  assign ramp_busy = 1'b0;
`endif

  // Shadow writes, commit mask capture and the shadow-to-active transfer.
  // NOTE: this small register file is reset explicitly because every field
  // must read 0 after reset; large RAM-style storage would be left unreset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      mask_q <= '0;
    end else begin
      if (wr_fire && !is_commit) begin
        case (wr_fld)
          FLD_AMP:    shadow_q[wr_ch].amp       <= wr.data;
          FLD_OFFSET: shadow_q[wr_ch].offset    <= wr.data;
          FLD_PHASE:  shadow_q[wr_ch].phaseword <= wr.data;
          FLD_DIV:    shadow_q[wr_ch].divisor   <= wr.data;
          FLD_RUN:    shadow_q[wr_ch].run       <= wr.data[0];
          default:    ;
        endcase
      end

      if (commit_fire) mask_q <= wr.data[3:0];

      for (int i = 0; i < NUM_CH; i++) begin
        if (apply && mask_q[i]) begin
`ifdef WAVE_CTRL_AMP_RAMP_EN
          active_q[i].offset    <= shadow_q[i].offset;
          active_q[i].phaseword <= shadow_q[i].phaseword;
          active_q[i].divisor   <= shadow_q[i].divisor;
          active_q[i].run       <= shadow_q[i].run;
          active_q[i].amp       <= amp_step[i];
        end else if (frame_tick && ramp_q[i]) begin
          active_q[i].amp       <= amp_step[i];
`else
          active_q[i] <= shadow_q[i];
`endif
        end
      end
    end
  end

  // Pack the active registers onto the output buses, channel 0 in the LSBs.
  always_comb begin
    amps       = '0;
    offsets    = '0;
    phasewords = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      amps[i*16 +: 16]       = active_q[i].amp;
      offsets[i*16 +: 16]    = active_q[i].offset;
      phasewords[i*16 +: 16] = active_q[i].phaseword;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_div
    wave_ctrl_div #(
      .DIV_W (DIV_W)
    ) u_div (
      .clk     (clk),
      .reset   (reset),
      .run     (active_q[g].run),
      .divisor (DIV_W'(active_q[g].divisor)),
      .clear   (apply && mask_q[g]),
      .strobe  (clks[g])
    );
  end

endmodule

// File: tb/tb_wave_ctrl.sv
// Self-checking bench for wave_ctrl. A small model tracks shadow and active
// register contents; each commit's expected bus image is queued when the
// applying frame_tick is driven and compared once the controller settles.
module tb_wave_ctrl;

`ifdef WAVE_CTRL_AMP_RAMP_EN
  localparam bit RAMP_ON = 1'b1;
`else
  localparam bit RAMP_ON = 1'b0;
`endif
  localparam logic [15:0] STEP = 16'd64;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] o;
    logic [63:0] p;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_tick = 1'b0;
  logic [63:0] amps, offsets, phasewords;
  logic [3:0]  clks;
  logic        busy;

  wave_ctrl_if wr_bus ();

  wave_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr_bus),
    .frame_tick (frame_tick),
    .amps       (amps),
    .offsets    (offsets),
    .phasewords (phasewords),
    .clks       (clks),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int last_acc;
  int tick_cyc;

  logic [15:0] m_sh_amp [4], m_sh_off [4], m_sh_ph [4];
  logic [15:0] m_ac_amp [4], m_ac_off [4], m_ac_ph [4];
  exp_t        sb [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_sh_amp[i] = '0; m_sh_off[i] = '0; m_sh_ph[i] = '0;
      m_ac_amp[i] = '0; m_ac_off[i] = '0; m_ac_ph[i] = '0;
    end
    sb.delete();
  endtask

  task automatic model_write(input logic [4:0] a, input logic [15:0] d);
    if (a != 5'h1F) begin
      case (a[2:0])
        3'd0: m_sh_amp[a[4:3]] = d;
        3'd1: m_sh_off[a[4:3]] = d;
        3'd2: m_sh_ph[a[4:3]]  = d;
        default: ;
      endcase
    end
  endtask

  task automatic exp_now(output exp_t e);
    e = '0;
    for (int i = 0; i < 4; i++) begin
      e.a[i*16 +: 16] = m_ac_amp[i];
      e.o[i*16 +: 16] = m_ac_off[i];
      e.p[i*16 +: 16] = m_ac_ph[i];
    end
  endtask

  // Final expected image after a commit of mask m has fully taken effect.
  task automatic model_apply(input logic [3:0] m);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        m_ac_amp[i] = m_sh_amp[i];
        m_ac_off[i] = m_sh_off[i];
        m_ac_ph[i]  = m_sh_ph[i];
      end
    end
    exp_now(e);
    sb.push_back(e);
  endtask

  task automatic sb_compare(input string tag);
    exp_t e;
    check({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_amps"}, amps, e.a);
      check({tag, "_offsets"}, offsets, e.o);
      check({tag, "_phasewords"}, phasewords, e.p);
    end
  endtask

  task automatic host_write(input logic [4:0] a, input logic [15:0] d);
    int n;
    n = 0;
    wr_bus.valid = 1'b1;
    wr_bus.addr  = a;
    wr_bus.data  = d;
    @(negedge clk);
    while (wr_bus.ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (wr_bus.ready !== 1'b1) begin
      check("wr_timeout", wr_bus.ready, 1);
      wr_bus.valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last_acc     = cyc;
    wr_bus.valid = 1'b0;
    model_write(a, d);
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    tick_cyc   = cyc;
    frame_tick = 1'b0;
  endtask

  // Keep ticking until any amplitude ramp has finished (immediate otherwise).
  task automatic settle();
    for (int n = 0; n < 100 && busy === 1'b1; n++) begin
      pulse_tick();
      repeat (2) @(negedge clk);
    end
    check("settle_busy", busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t        e;
    logic [3:0]  obs [16];
    logic [15:0] v;
    int          p;

    wr_bus.valid = 1'b0;
    wr_bus.addr  = '0;
    wr_bus.data  = '0;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready_low", wr_bus.ready, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", wr_bus.ready, 1);
    check("post_rst_amps", amps, 0);
    check("post_rst_offsets", offsets, 0);
    check("post_rst_phase", phasewords, 0);
    check("post_rst_clks", clks, 0);

    // ch0 amp commit: exact visibility two cycles after the tick edge.
    host_write({2'd0, 3'd0}, 16'h1234);
    host_write({2'd0, 3'd1}, 16'h0011);
    host_write({2'd0, 3'd2}, 16'h0101);
    host_write(5'h1F, 16'h0001);
    @(negedge clk);
    check("t1_busy_wait", busy, 1);
    check("t1_ready_wait", wr_bus.ready, 0);
    check("t1_shadow_hidden", amps, 0);
    pulse_tick();
    model_apply(4'h1);
    @(negedge clk);
    check("t1_busy_apply", busy, 1);
    check("t1_amp_pre", amps[15:0], 0);
    @(negedge clk);
    check("t1_amp_post", amps[15:0], RAMP_ON ? 64'd64 : 64'h1234);
    check("t1_busy_after", busy, RAMP_ON);
    check("t1_upper_ch", amps[63:16], 0);
    settle();
    sb_compare("t1");

    // ch2 divider: divisor 3, run 1 -> strobe every 4th cycle.
    host_write({2'd2, 3'd3}, 16'd3);
    host_write({2'd2, 3'd4}, 16'd1);
    host_write(5'h1F, 16'h0004);
    @(negedge clk);
    check("t2_clks_idle", clks, 0);
    pulse_tick();
    model_apply(4'h4);
    repeat (2) @(negedge clk);
    settle();
    sb_compare("t2");
    for (int k = 0; k < 16; k++) begin
      obs[k] = clks;
      @(negedge clk);
    end
    p = -1;
    for (int k = 15; k >= 0; k--) if (obs[k][2]) p = k;
    check("t2_first_pulse", (p >= 0 && p < 5), 1);
    for (int k = 0; k < 16; k++)
      check("t2_clks", obs[k], (p >= 0 && k >= p && (k - p) % 4 == 0) ? 4'b0100 : 4'b0000);

    // Last shadow value wins; a write held during WAIT lands after APPLY.
    host_write({2'd1, 3'd0}, 16'hAAAA);
    host_write({2'd1, 3'd0}, 16'h0040);
    host_write({2'd3, 3'd2}, 16'hBEEF);
    host_write(5'h1F, 16'h000A);
    fork
      host_write({2'd0, 3'd1}, 16'h0BEE);
      begin
        repeat (3) begin
          @(negedge clk);
          check("t3_ready_wait", wr_bus.ready, 0);
        end
        pulse_tick();
        model_apply(4'hA);
      end
    join
    check("t3_accept_cycle", last_acc, tick_cyc + 2);
    @(negedge clk);
    settle();
    sb_compare("t3");

    // Mask 0 commit: accepted, nothing armed.
    host_write(5'h1F, 16'h0000);
    @(negedge clk);
    check("t4_mask0_busy", busy, 0);
    check("t4_mask0_ready", wr_bus.ready, 1);

    // Commit and frame_tick in the same cycle: that tick is not used.
    host_write({2'd3, 3'd0}, 16'h0030);
    frame_tick   = 1'b1;
    wr_bus.valid = 1'b1;
    wr_bus.addr  = 5'h1F;
    wr_bus.data  = 16'h0008;
    @(negedge clk);
    check("t5_ready_same", wr_bus.ready, 1);
    @(posedge clk);
    #1;
    frame_tick   = 1'b0;
    wr_bus.valid = 1'b0;
    repeat (3) @(negedge clk);
    exp_now(e);
    check("t5_busy_held", busy, 1);
    check("t5_amps_held", amps, e.a);
    pulse_tick();
    model_apply(4'h8);
    repeat (2) @(negedge clk);
    settle();
    sb_compare("t5");

    // Reset while in WAIT clears everything; a later tick changes nothing.
    host_write({2'd1, 3'd0}, 16'h4321);
    host_write(5'h1F, 16'h0002);
    @(negedge clk);
    check("t6_busy_wait", busy, 1);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("t6_amps", amps, 0);
    check("t6_offsets", offsets, 0);
    check("t6_phase", phasewords, 0);
    check("t6_clks", clks, 0);
    check("t6_busy", busy, 0);
    check("t6_ready", wr_bus.ready, 1);
    pulse_tick();
    repeat (3) @(negedge clk);
    check("t6_tick_amps", amps, 0);
    check("t6_tick_busy", busy, 0);
    check("t6_tick_clks", clks, 0);

`ifdef WAVE_CTRL_AMP_RAMP_EN
    // ch1 ramps 0 -> 200 in steps of 64, clamping on the last tick.
    host_write({2'd1, 3'd0}, 16'd200);
    host_write(5'h1F, 16'h0002);
    v = 16'd0;
    for (int s = 0; s < 4; s++) begin
      pulse_tick();
      repeat (2) @(negedge clk);
      v = (16'd200 - v > STEP) ? v + STEP : 16'd200;
      check("t7_ramp_amp", amps[31:16], v);
      check("t7_ramp_busy", busy, v != 16'd200);
    end
    check("t7_ready", wr_bus.ready, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
